// File: rtl/stream_cypher_ctrl_if.sv
// Handshake and session-control bundle for the XOR stream-cypher sequencer.
// The master side drives a session; the slave side is the sequencer itself.
interface stream_cypher_ctrl_if #(
    parameter int unsigned LFSR_W = 16,
    parameter int unsigned LEN_W  = 8
);
    logic              start;
    logic [LFSR_W-1:0] seed;
    logic [LEN_W-1:0]  len;
    logic              abort;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        otp_out;
    logic              busy;
    logic              done;

    modport master (
        output start, seed, len, abort, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, otp_out, busy, done
    );

    modport slave (
        input  start, seed, len, abort, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, otp_out, busy, done
    );
endinterface

// File: rtl/stream_cypher_ctrl.sv
// XOR stream-cypher sequencer: Galois LFSR keystream, per-session byte count,
// one registered output stage with valid/ready backpressure.
module stream_cypher_ctrl #(
    parameter int unsigned          LFSR_W       = 16,
    parameter logic [LFSR_W-1:0]    POLY         = 16'hB400,
    parameter logic [LFSR_W-1:0]    DEFAULT_SEED = 16'hACE1,
    parameter int unsigned          LEN_W        = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    stream_cypher_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [LFSR_W-1:0] lfsr;
    logic [LEN_W-1:0]  remaining;
    logic [7:0]        out_data_r;
    logic              out_valid_r;
    logic              in_ready_c;
    logic              accept;
    logic              out_free;

    // One keystream byte consumes eight Galois shifts.
    function automatic logic [LFSR_W-1:0] advance8(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] v;
        v = s;
        for (int unsigned i = 0; i < 8; i++) begin
            v = v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
        end
        return v;
    endfunction

    assign out_free = !out_valid_r || bus.out_ready;
    assign accept   = in_ready_c && bus.in_valid && !bus.abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        in_ready_c = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                in_ready_c = (remaining != '0) && out_free;
                if ((remaining == '0) && out_free) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.abort) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr        <= DEFAULT_SEED;
            remaining   <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
        end else if (bus.abort) begin
            remaining   <= '0;
            out_valid_r <= 1'b0;
        end else begin
            // An all-zero seed would lock the LFSR, so it falls back to the default.
            if ((state == IDLE) && bus.start) begin
                lfsr      <= (bus.seed == '0) ? DEFAULT_SEED : bus.seed;
                remaining <= bus.len;
            end
            if (accept) begin
                out_data_r  <= bus.in_data ^ lfsr[7:0];
                out_valid_r <= 1'b1;
                remaining   <= remaining - LEN_W'(1);
                lfsr        <= advance8(lfsr);
            end else if (out_valid_r && bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = out_data_r;
    assign bus.out_valid = out_valid_r;
    assign bus.otp_out   = lfsr[7:0];
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
endmodule
